// File: rtl/fp_align_pkg.sv
// Shared constants and types for the fp_align operand alignment stage.
package fp_align_pkg;
    localparam int EW      = 8;
    localparam int MW      = 28;
    localparam int UW      = 1 + EW + MW;
    localparam int SGN     = 36;
    localparam int EXP_HI  = 35;
    localparam int EXP_LO  = 28;
    localparam int MANT_HI = 27;

    // Exponent value marking Inf/NaN operands
    localparam logic [EW-1:0] EXP_SPECIAL = 8'hFF;

    // Distances at or beyond this collapse the mantissa to a lone sticky bit
    localparam logic [EW-1:0] BIG_SHIFT = 8'd27;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/fp_align_if.sv
// Operand/result handshake bundle for fp_align.
interface fp_align_if;
    import fp_align_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   A;
    logic [31:0]   B;
    logic          out_valid;
    logic          out_ready;
    logic [UW-1:0] NA;
    logic [UW-1:0] NB;
    logic          out_spec;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, NA, NB, out_spec
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, NA, NB, out_spec
    );
endinterface

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single -> {sign, eff_exp, mant[27:0]} unpacker.
module fp_unpack
    import fp_align_pkg::*;
(
    input  logic [31:0]   word,
    output logic [UW-1:0] unp
);
    logic [EW-1:0] exp_raw;
    logic [22:0]   frac;

    assign exp_raw = word[30:23];
    assign frac    = word[22:0];

    // Denormals/zero get effective exponent 1 and no hidden bit
    always_comb begin
        if (exp_raw != '0) begin
            unp = {word[31], exp_raw, 2'b01, frac, 3'b000};
        end else begin
            unp = {word[31], 8'd1, 2'b00, frac, 3'b000};
        end
    end
endmodule

// File: rtl/fp_align.sv
// Iterative exponent alignment: shifts the smaller-exponent mantissa right
// with sticky until both operands share the larger exponent.
module fp_align
    import fp_align_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    fp_align_if.slave  bus
);
    localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

    logic [UW-1:0] ua, ub;
    state_t        state_q, state_d;
    logic [UW-1:0] na_q, na_d, nb_q, nb_d;
    logic          spec_q, spec_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          tgt_b_q, tgt_b_d;
    logic          in_ready, out_valid, accept;
    logic [EW-1:0] ea, eb, emax, diff;
    logic          a_small, acc_spec;
    state_t        acc_state;
    logic [4:0]    step_amt;

    // Right shift by s; every bit pushed out (old bit0 included) ORs into new bit0
    function automatic logic [MW-1:0] sticky_shr(input logic [MW-1:0] m, input logic [4:0] s);
        logic [MW-1:0] lost_mask;
        lost_mask  = ~({MW{1'b1}} << s);
        sticky_shr = (m >> s) | {{(MW-1){1'b0}}, |(m & lost_mask)};
    endfunction

    // Shift distance large enough that only the sticky survives
    function automatic logic [MW-1:0] collapse(input logic [MW-1:0] m);
        collapse = {{(MW-1){1'b0}}, |m};
    endfunction

    fp_unpack u_unpack_a (.word(bus.A), .unp(ua));
    fp_unpack u_unpack_b (.word(bus.B), .unp(ub));

    // Decode the incoming pair: exponent distance, target side, special flag
    always_comb begin
        ea        = ua[EXP_HI:EXP_LO];
        eb        = ub[EXP_HI:EXP_LO];
        a_small   = (ea < eb);
        diff      = a_small ? (eb - ea) : (ea - eb);
        emax      = a_small ? eb : ea;
        acc_spec  = (ea == EXP_SPECIAL) || (eb == EXP_SPECIAL);
        acc_state = (acc_spec || diff == '0 || diff >= BIG_SHIFT) ? ST_HOLD : ST_SHIFT;
        step_amt  = (cnt_q < STEP5) ? cnt_q : STEP5;
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            na_q    <= '0;
            nb_q    <= '0;
            spec_q  <= 1'b0;
            cnt_q   <= '0;
            tgt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            spec_q  <= spec_d;
            cnt_q   <= cnt_d;
            tgt_b_q <= tgt_b_d;
        end
    end

    // Next-state logic; a HOLD drain may chain straight into a new pair
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = acc_state;
            ST_SHIFT: if (cnt_q <= STEP5) state_d = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) state_d = accept ? acc_state : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        out_valid = (state_q == ST_HOLD);
        in_ready  = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.out_ready));
        accept    = bus.in_valid & in_ready;
    end

    // Operand capture on accept, one sticky shift step per SHIFT cycle
    always_comb begin
        na_d    = na_q;
        nb_d    = nb_q;
        spec_d  = spec_q;
        cnt_d   = cnt_q;
        tgt_b_d = tgt_b_q;
        if (accept) begin
            na_d    = ua;
            nb_d    = ub;
            spec_d  = acc_spec;
            cnt_d   = '0;
            tgt_b_d = ~a_small;
            if (!acc_spec) begin
                na_d[EXP_HI:EXP_LO] = emax;
                nb_d[EXP_HI:EXP_LO] = emax;
                if (diff >= BIG_SHIFT) begin
                    if (a_small) na_d[MANT_HI:0] = collapse(ua[MANT_HI:0]);
                    else         nb_d[MANT_HI:0] = collapse(ub[MANT_HI:0]);
                end else begin
                    cnt_d = diff[4:0];
                end
            end
        end else if (state_q == ST_SHIFT) begin
            if (tgt_b_q) nb_d[MANT_HI:0] = sticky_shr(nb_q[MANT_HI:0], step_amt);
            else         na_d[MANT_HI:0] = sticky_shr(na_q[MANT_HI:0], step_amt);
            cnt_d = cnt_q - step_amt;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.NA        = na_q;
    assign bus.NB        = nb_q;
    assign bus.out_spec  = spec_q;
endmodule

// File: tb/tb_fp_align.sv
// Self-checking bench for fp_align with SHIFT_STEP=4.
module tb_fp_align;
    import fp_align_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_align_if bus();

    fp_align #(.SHIFT_STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference unpack from the IEEE field rules
    function automatic void ref_unpack(input logic [31:0] w, output int e, output longint m);
        if (w[30:23] == 8'd0) begin
            e = 1;
            m = longint'(w[22:0]) * 8;
        end else begin
            e = int'(w[30:23]);
            m = (longint'(1) << 26) + longint'(w[22:0]) * 8;
        end
    endfunction

    // One-shot sticky right shift: equivalent to any sequence of sticky steps
    function automatic longint ref_shift(input longint m, input int d);
        longint lost;
        if (d >= 40) return (m != 0) ? 1 : 0;
        lost = m % (longint'(1) << d);
        return (m >> d) | ((lost != 0) ? 1 : 0);
    endfunction

    function automatic void ref_align(input logic [31:0] a, input logic [31:0] b,
                                      output logic [36:0] na, output logic [36:0] nb,
                                      output logic spec, output int lat);
        int ea, eb, d, emax;
        longint ma, mb;
        ref_unpack(a, ea, ma);
        ref_unpack(b, eb, mb);
        spec = (ea == 255) || (eb == 255);
        if (spec) begin
            na  = {a[31], 8'(ea), 28'(ma)};
            nb  = {b[31], 8'(eb), 28'(mb)};
            lat = 1;
            return;
        end
        d    = (ea > eb) ? ea - eb : eb - ea;
        emax = (ea > eb) ? ea : eb;
        if (ea < eb) ma = ref_shift(ma, d);
        if (eb < ea) mb = ref_shift(mb, d);
        na  = {a[31], 8'(emax), 28'(ma)};
        nb  = {b[31], 8'(emax), 28'(mb)};
        lat = (d == 0 || d >= 27) ? 1 : 1 + (d + 3) / 4;
    endfunction

    // Offer one pair from IDLE, wait for the result and compare; optionally drain it
    task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input bit drain, output logic [36:0] na_o, output logic [36:0] nb_o);
        logic [36:0] ena, enb;
        logic        espec;
        int          elat, lat;
        ref_align(a, b, ena, enb, espec, elat);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(1'b1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(elat));
        chk({tag, ".spec"}, 64'(bus.out_spec), 64'(espec));
        if (espec) begin
            chk({tag, ".NA_mant"}, 64'({bus.NA[36], bus.NA[27:0]}), 64'({ena[36], ena[27:0]}));
            chk({tag, ".NB_mant"}, 64'({bus.NB[36], bus.NB[27:0]}), 64'({enb[36], enb[27:0]}));
        end else begin
            chk({tag, ".NA"}, 64'(bus.NA), 64'(ena));
            chk({tag, ".NB"}, 64'(bus.NB), 64'(enb));
        end
        na_o = bus.NA;
        nb_o = bus.NB;
        if (drain) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] na, nb, hold_na, hold_nb, ena, enb;
        logic        espec;
        int          elat, ea, eb;
        logic [31:0] wa, wb;
        bit          leaked;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst.NA", 64'(bus.NA), 64'(0));
        chk("rst.NB", 64'(bus.NB), 64'(0));
        chk("rst.out_spec", 64'(bus.out_spec), 64'(0));
        chk("rst.in_ready", 64'(bus.in_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 64'(bus.in_ready), 64'(1));

        // Directed pairs, including hand-computed values
        run_pair("t1", 32'h3F800000, 32'h3F800000, 1'b1, na, nb);
        chk("t1.NB_const", 64'(nb), 64'({1'b0, 8'h7F, 28'h4000000}));
        run_pair("t2", 32'h3F800000, 32'h3F000000, 1'b1, na, nb);
        chk("t2.NB_const", 64'(nb), 64'({1'b0, 8'h7F, 28'h2000000}));
        chk("t2.NA_const", 64'(na), 64'({1'b0, 8'h7F, 28'h4000000}));
        run_pair("t3", 32'h42000000, 32'h3F800001, 1'b1, na, nb);
        chk("t3.NB_const", 64'(nb), 64'({1'b0, 8'h84, 28'h0200001}));
        run_pair("t4", 32'h3F800000, 32'h30800000, 1'b1, na, nb);
        chk("t4.NB_const", 64'(nb), 64'({1'b0, 8'h7F, 28'h0000001}));
        run_pair("t4s", 32'h7F800000, 32'h30800000, 1'b1, na, nb);
        run_pair("denorm", 32'h80000003, 32'h00400000, 1'b1, na, nb);
        chk("denorm.exp", 64'(nb[35:28]), 64'(8'h01));
        run_pair("d26", 32'h4C800000, 32'h3F800007, 1'b1, na, nb);

        // Backpressure: result must stay put and input side stays closed
        run_pair("t5", 32'h3F800000, 32'h3F000000, 1'b0, hold_na, hold_nb);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t5.hold%0d.NA", i), 64'(bus.NA), 64'(hold_na));
            chk($sformatf("t5.hold%0d.NB", i), 64'(bus.NB), 64'(hold_nb));
            chk($sformatf("t5.hold%0d.in_ready", i), 64'(bus.in_ready), 64'(0));
            chk($sformatf("t5.hold%0d.out_valid", i), 64'(bus.out_valid), 64'(1));
        end
        // Drain and accept in the same cycle
        ref_align(32'h40400000, 32'hC0400000, ena, enb, espec, elat);
        bus.A = 32'h40400000;
        bus.B = 32'hC0400000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t5.b2b.in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5.b2b.out_valid", 64'(bus.out_valid), 64'(1));
        chk("t5.b2b.NA", 64'(bus.NA), 64'(ena));
        chk("t5.b2b.NB", 64'(bus.NB), 64'(enb));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Reset in the middle of a SHIFT sequence
        @(negedge clk);
        bus.A = 32'h42000000;
        bus.B = 32'h3F800001;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t6.shifting", 64'(bus.out_valid), 64'(0));
        rst = 1'b1;
        #1;
        chk("t6.rst.in_ready", 64'(bus.in_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6.out_valid", 64'(bus.out_valid), 64'(0));
        chk("t6.in_ready", 64'(bus.in_ready), 64'(1));
        leaked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) leaked = 1'b1;
        end
        chk("t6.no_leak", 64'(leaked), 64'(0));

        // Randomized pairs against the reference model
        for (int i = 0; i < 40; i++) begin
            ea = (($urandom % 8) == 0) ? 255 : int'($urandom_range(0, 254));
            eb = ea + int'($urandom_range(0, 70)) - 35;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            if (($urandom % 10) == 0) eb = 0;
            wa = {1'($urandom), 8'(ea), 23'($urandom)};
            wb = {1'($urandom), 8'(eb), 23'($urandom)};
            run_pair($sformatf("rnd%0d", i), wa, wb, 1'b1, na, nb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
